// File: rtl/uartx_pkg.sv
// Shared definitions for the uartx transceiver: parity modes, rxerr bit
// positions and the frame-state encoding used by both TX and RX.
package uartx_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam int ERR_FRAME   = 0;
    localparam int ERR_PARITY  = 1;
    localparam int ERR_OVERRUN = 2;

    // Wide enough to count up to 9 data bits or 2 stop bits.
    localparam int BITCNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uartx_rx.sv
// uartx receiver: 2-flop input synchronizer, mid-bit sampling frame FSM and
// the rxreq/rxack output register with frame, parity and overrun flags.
module uartx_rx
    import uartx_pkg::*;
#(
    parameter int DATABITS = 8,
    parameter int PARITY   = 0,
    parameter int CLKDIV   = 434
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                rx,
    input  logic                rxack,
    output logic                rxreq,
    output logic [DATABITS-1:0] rxdata,
    output logic [2:0]          rxerr
);

    localparam int                CW        = cnt_width(CLKDIV);
    localparam logic [CW-1:0]     BAUD_LAST = CW'(CLKDIV - 1);
    localparam logic [CW-1:0]     HALF_LAST = CW'(CLKDIV / 2 - 1);
    localparam logic [BITCNT_W-1:0] DATA_LAST = BITCNT_W'(DATABITS - 1);
    localparam logic              ODD       = (PARITY == PAR_ODD);

    logic                rx_s1, rx_s2, rx_prev;
    uart_state_e         state_q, state_d;
    logic [CW-1:0]       baud_q, baud_d;
    logic [BITCNT_W-1:0] bit_q, bit_d;
    logic [DATABITS-1:0] shreg_q, shreg_d;
    logic                par_err_q, par_err_d;
    logic                done;
    logic [2:0]          err_d;
    logic                rxreq_q;
    logic [DATABITS-1:0] rxdata_q;
    logic [2:0]          rxerr_q;

    logic baud_end;
    assign baud_end = (baud_q == BAUD_LAST);

    // Idle-high reset keeps a quiet line from looking like a start edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_err_d = par_err_q;
        done      = 1'b0;
        err_d     = '0;

        case (state_q)
            ST_IDLE: begin
                if (rx_prev && !rx_s2) begin
                    state_d = ST_START;
                    baud_d  = '0;
                end
            end
            ST_START: begin
                baud_d = baud_q + 1'b1;
                if (baud_q == HALF_LAST) begin
                    baud_d    = '0;
                    bit_d     = '0;
                    par_err_d = 1'b0;
                    state_d   = rx_s2 ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    shreg_d = {rx_s2, shreg_q[DATABITS-1:1]};
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    par_err_d = rx_s2 ^ (^shreg_q) ^ ODD;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                baud_d = baud_end ? '0 : baud_q + 1'b1;
                if (baud_end) begin
                    done                = 1'b1;
                    err_d[ERR_FRAME]    = ~rx_s2;
                    err_d[ERR_PARITY]   = par_err_q;
                    // An ack landing with the completion means the old word was taken.
                    err_d[ERR_OVERRUN]  = rxreq_q & ~rxack;
                    state_d             = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            par_err_q <= par_err_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxreq_q  <= 1'b0;
            rxdata_q <= '0;
            rxerr_q  <= '0;
        end else if (done) begin
            rxreq_q  <= 1'b1;
            rxdata_q <= shreg_q;
            rxerr_q  <= err_d;
        end else if (rxack && rxreq_q) begin
            rxreq_q <= 1'b0;
        end
    end

    assign rxreq  = rxreq_q;
    assign rxdata = rxdata_q;
    assign rxerr  = rxerr_q;

endmodule

// File: rtl/uartx.sv
// uartx top: parametrised UART transceiver. The transmit FSM lives here;
// the receive path is the uartx_rx sub-module.
module uartx
    import uartx_pkg::*;
#(
    parameter int DATABITS = 8,
    parameter int PARITY   = 0,
    parameter int STOPBITS = 1,
    parameter int CLKDIV   = 434
) (
    input  logic                clk,
    input  logic                rstn,
    output logic                tx,
    input  logic                rx,
    input  logic                txreq,
    output logic                txack,
    input  logic [DATABITS-1:0] txdata,
    output logic                rxreq,
    input  logic                rxack,
    output logic [DATABITS-1:0] rxdata,
    output logic [2:0]          rxerr
);

    localparam int                  CW        = cnt_width(CLKDIV);
    localparam logic [CW-1:0]       BAUD_LAST = CW'(CLKDIV - 1);
    localparam logic [BITCNT_W-1:0] DATA_LAST = BITCNT_W'(DATABITS - 1);
    localparam logic [BITCNT_W-1:0] STOP_LAST = BITCNT_W'(STOPBITS - 1);
    localparam logic                ODD       = (PARITY == PAR_ODD);

    uart_state_e         state_q, state_d;
    logic [CW-1:0]       baud_q, baud_d;
    logic [BITCNT_W-1:0] bit_q, bit_d;
    logic [DATABITS-1:0] shreg_q, shreg_d;
    logic                par_q, par_d;
    logic                tx_q, tx_d;
    logic                txack_q, txack_d;

    logic baud_end;
    assign baud_end = (baud_q == BAUD_LAST);

    // tx_d is the line level for the current state; registering it gives a
    // glitch-free pin and the one-cycle lag between acceptance and start bit.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        baud_d  = (state_q == ST_IDLE || baud_end) ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = 1'b1;
        txack_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (txreq) begin
                    state_d = ST_START;
                    shreg_d = txdata;
                    par_d   = (^txdata) ^ ODD;
                    bit_d   = '0;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (baud_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                tx_d = shreg_q[0];
                if (baud_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                tx_d = par_q;
                if (baud_end) state_d = ST_STOP;
            end
            ST_STOP: begin
                tx_d = 1'b1;
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        txack_d = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            txack_q <= 1'b0;
        end else begin
            // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            txack_q <= txack_d;
        end
    end

    assign tx    = tx_q;
    assign txack = txack_q;

    uartx_rx #(
        .DATABITS(DATABITS),
        .PARITY  (PARITY),
        .CLKDIV  (CLKDIV)
    ) u_rx (
        .clk   (clk),
        .rstn  (rstn),
        .rx    (rx),
        .rxack (rxack),
        .rxreq (rxreq),
        .rxdata(rxdata),
        .rxerr (rxerr)
    );

endmodule

// File: tb/tb_uartx.sv
// Directed self-checking bench for uartx: three instances cover 8N1/div4,
// 7E2/div4 (driven or looped back) and 8N1/div8 for the glitch case.
module tb_uartx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    int   errors = 0;
    int   checks = 0;

    logic       rx_drv;
    int         rx_dst;
    logic       loop_b;

    logic       tx_a, rx_a, txreq_a, txack_a, rxreq_a, rxack_a;
    logic [7:0] txdata_a, rxdata_a;
    logic [2:0] rxerr_a;

    logic       tx_b, rx_b, txreq_b, txack_b, rxreq_b, rxack_b;
    logic [6:0] txdata_b, rxdata_b;
    logic [2:0] rxerr_b;

    logic       tx_c, rx_c, txreq_c, txack_c, rxreq_c, rxack_c;
    logic [7:0] txdata_c, rxdata_c;
    logic [2:0] rxerr_c;

    assign rx_a = (rx_dst == 0) ? rx_drv : 1'b1;
    assign rx_b = loop_b ? tx_b : ((rx_dst == 1) ? rx_drv : 1'b1);
    assign rx_c = (rx_dst == 2) ? rx_drv : 1'b1;

    uartx #(.DATABITS(8), .PARITY(0), .STOPBITS(1), .CLKDIV(4)) u_a (
        .clk(clk), .rstn(rstn), .tx(tx_a), .rx(rx_a), .txreq(txreq_a), .txack(txack_a),
        .txdata(txdata_a), .rxreq(rxreq_a), .rxack(rxack_a), .rxdata(rxdata_a), .rxerr(rxerr_a)
    );

    uartx #(.DATABITS(7), .PARITY(2), .STOPBITS(2), .CLKDIV(4)) u_b (
        .clk(clk), .rstn(rstn), .tx(tx_b), .rx(rx_b), .txreq(txreq_b), .txack(txack_b),
        .txdata(txdata_b), .rxreq(rxreq_b), .rxack(rxack_b), .rxdata(rxdata_b), .rxerr(rxerr_b)
    );

    uartx #(.DATABITS(8), .PARITY(0), .STOPBITS(1), .CLKDIV(8)) u_c (
        .clk(clk), .rstn(rstn), .tx(tx_c), .rx(rx_c), .txreq(txreq_c), .txack(txack_c),
        .txdata(txdata_c), .rxreq(rxreq_c), .rxack(rxack_c), .rxdata(rxdata_c), .rxerr(rxerr_c)
    );

    // Drives a frame LSB first onto the selected rx input; call at a negedge.
    task automatic drive_frame(input logic [15:0] bits, input int n, input int div, input int dst);
        rx_dst = dst;
        for (int i = 0; i < n; i++) begin
            rx_drv = bits[i];
            repeat (div) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        rx_drv = 1'b1; rx_dst = -1; loop_b = 1'b0;
        txreq_a = 1'b0; rxack_a = 1'b0; txdata_a = '0;
        txreq_b = 1'b0; rxack_b = 1'b0; txdata_b = '0;
        txreq_c = 1'b0; rxack_c = 1'b0; txdata_c = '0;
        repeat (3) @(negedge clk);
        checks++; if (tx_a !== 1'b1)     begin errors++; $display("FAIL reset_tx: got %b expected 1", tx_a); end
        checks++; if (txack_a !== 1'b0)  begin errors++; $display("FAIL reset_txack: got %b expected 0", txack_a); end
        checks++; if (rxreq_a !== 1'b0)  begin errors++; $display("FAIL reset_rxreq: got %b expected 0", rxreq_a); end
        checks++; if (rxdata_a !== 8'h00) begin errors++; $display("FAIL reset_rxdata: got %h expected 00", rxdata_a); end
        checks++; if (rxerr_a !== 3'b000) begin errors++; $display("FAIL reset_rxerr: got %b expected 000", rxerr_a); end
        checks++; if (tx_b !== 1'b1)     begin errors++; $display("FAIL reset_tx_b: got %b expected 1", tx_b); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    // Sends d on u_a and checks each bit mid-cell plus txack on every cycle.
    task automatic test_tx_frame(input logic [7:0] d, input logic [9:0] exp, input string name);
        @(negedge clk);
        txdata_a = d;
        txreq_a  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        txreq_a  = 1'b0;
        for (int c = 1; c <= 41; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c <= 40 && (c - 1) % 4 == 1) begin
                checks++;
                if (tx_a !== exp[(c - 1) / 4]) begin
                    errors++;
                    $display("FAIL %s_bit%0d: got %b expected %b", name, (c - 1) / 4, tx_a, exp[(c - 1) / 4]);
                end
            end
            checks++;
            if (txack_a !== (c == 40)) begin
                errors++;
                $display("FAIL %s_txack_cycle%0d: got %b expected %b", name, c, txack_a, (c == 40));
            end
        end
    endtask

    task automatic test_overrun();
        int n;
        @(negedge clk);
        drive_frame(16'b000000_1000100010, 10, 4, 0);
        n = 0;
        while (rxreq_a !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        checks++; if (rxreq_a !== 1'b1)   begin errors++; $display("FAIL ovr_first_rxreq: got %b expected 1", rxreq_a); end
        checks++; if (rxdata_a !== 8'h11) begin errors++; $display("FAIL ovr_first_data: got %h expected 11", rxdata_a); end
        checks++; if (rxerr_a !== 3'b000) begin errors++; $display("FAIL ovr_first_err: got %b expected 000", rxerr_a); end
        drive_frame(16'b000000_1001000100, 10, 4, 0);
        repeat (6) @(negedge clk);
        checks++; if (rxreq_a !== 1'b1)   begin errors++; $display("FAIL ovr_rxreq: got %b expected 1", rxreq_a); end
        checks++; if (rxdata_a !== 8'h22) begin errors++; $display("FAIL ovr_data: got %h expected 22", rxdata_a); end
        checks++; if (rxerr_a !== 3'b100) begin errors++; $display("FAIL ovr_err: got %b expected 100", rxerr_a); end
        rxack_a = 1'b1;
        @(negedge clk);
        rxack_a = 1'b0;
        checks++; if (rxreq_a !== 1'b0)   begin errors++; $display("FAIL ovr_ack_clear: got %b expected 0", rxreq_a); end
    endtask

    task automatic test_rx_errors();
        int n;
        loop_b = 1'b0;
        @(negedge clk);
        // 7'h55 with parity 1 where even parity needs 0
        drive_frame(16'b00000_11110101010, 11, 4, 1);
        n = 0;
        while (rxreq_b !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        checks++; if (rxreq_b !== 1'b1)   begin errors++; $display("FAIL par_rxreq: got %b expected 1", rxreq_b); end
        checks++; if (rxdata_b !== 7'h55) begin errors++; $display("FAIL par_data: got %h expected 55", rxdata_b); end
        checks++; if (rxerr_b !== 3'b010) begin errors++; $display("FAIL par_err: got %b expected 010", rxerr_b); end
        rxack_b = 1'b1;
        @(negedge clk);
        rxack_b = 1'b0;
        // 7'h2A with correct parity 1, first stop bit 0
        drive_frame(16'b00000_10101010100, 11, 4, 1);
        n = 0;
        while (rxreq_b !== 1'b1 && n < 30) begin @(negedge clk); n++; end
        checks++; if (rxreq_b !== 1'b1)   begin errors++; $display("FAIL frm_rxreq: got %b expected 1", rxreq_b); end
        checks++; if (rxdata_b !== 7'h2A) begin errors++; $display("FAIL frm_data: got %h expected 2a", rxdata_b); end
        checks++; if (rxerr_b !== 3'b001) begin errors++; $display("FAIL frm_err: got %b expected 001", rxerr_b); end
        rxack_b = 1'b1;
        @(negedge clk);
        rxack_b = 1'b0;
        rx_dst = -1;
    endtask

    task automatic test_back_to_back();
        rx_dst = -1;
        loop_b = 1'b1;
        fork
            begin
                int n;
                @(negedge clk);
                txdata_b = 7'h55; txreq_b = 1'b1;
                @(negedge clk);
                txreq_b = 1'b0;
                n = 0;
                while (txack_b !== 1'b1 && n < 100) begin @(negedge clk); n++; end
                checks++; if (txack_b !== 1'b1) begin errors++; $display("FAIL b2b_txack0: got %b expected 1", txack_b); end
                @(negedge clk);
                txdata_b = 7'h00; txreq_b = 1'b1;
                @(negedge clk);
                txreq_b = 1'b0;
                n = 0;
                while (txack_b !== 1'b1 && n < 100) begin @(negedge clk); n++; end
                checks++; if (txack_b !== 1'b1) begin errors++; $display("FAIL b2b_txack1: got %b expected 1", txack_b); end
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    logic [6:0] exp;
                    int m;
                    exp = (k == 0) ? 7'h55 : 7'h00;
                    m = 0;
                    while (rxreq_b !== 1'b1 && m < 200) begin @(negedge clk); m++; end
                    checks++; if (rxreq_b !== 1'b1)  begin errors++; $display("FAIL b2b_rxreq%0d: got %b expected 1", k, rxreq_b); end
                    checks++; if (rxdata_b !== exp)  begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", k, rxdata_b, exp); end
                    checks++; if (rxerr_b !== 3'b000) begin errors++; $display("FAIL b2b_err%0d: got %b expected 000", k, rxerr_b); end
                    rxack_b = 1'b1;
                    @(negedge clk);
                    rxack_b = 1'b0;
                end
            end
        join
        repeat (12) @(negedge clk);
        loop_b = 1'b0;
    endtask

    task automatic test_glitch();
        logic seen;
        int   n;
        @(negedge clk);
        rx_dst = 2;
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rxreq_c !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL glitch_rxreq: got %b expected 0", seen); end
        // A clean frame right after shows RX went back to IDLE.
        drive_frame(16'b000000_1001111000, 10, 8, 2);
        n = 0;
        while (rxreq_c !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++; if (rxreq_c !== 1'b1)   begin errors++; $display("FAIL glitch_after_rxreq: got %b expected 1", rxreq_c); end
        checks++; if (rxdata_c !== 8'h3C) begin errors++; $display("FAIL glitch_after_data: got %h expected 3c", rxdata_c); end
        checks++; if (rxerr_c !== 3'b000) begin errors++; $display("FAIL glitch_after_err: got %b expected 000", rxerr_c); end
        rxack_c = 1'b1;
        @(negedge clk);
        rxack_c = 1'b0;
        rx_dst = -1;
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        txdata_a = 8'hA5;
        txreq_a  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        txreq_a  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (tx_a !== 1'b0) begin errors++; $display("FAIL midrst_start_bit: got %b expected 0", tx_a); end
        #1 rstn = 1'b0;
        #1;
        checks++; if (tx_a !== 1'b1) begin errors++; $display("FAIL midrst_tx_async: got %b expected 1", tx_a); end
        @(negedge clk);
        rstn = 1'b1;
        test_tx_frame(8'h3C, 10'b1001111000, "after_rst");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_tx_frame(8'hA5, 10'b1101001010, "tx_a5");
        test_overrun();
        test_rx_errors();
        test_back_to_back();
        test_glitch();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
